// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery parameter generator: state encoding,
// default width, counter sizing helper and the register offsets it shares with the rsa wrapper.
package mont_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } mont_state_t;

  localparam int MONT_WIDTH = 32;

  // Same offsets as the rsa wrapper map, so software uses one address plan.
  localparam logic [7:0] WB_OFF_N        = 8'h00;
  localparam logic [7:0] WB_OFF_N_INV    = 8'h04;
  localparam logic [7:0] WB_OFF_R2_MOD_N = 8'h08;

  function automatic int clog2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mont_neg_inv.sv
// Bit-serial inverse of an odd modulus mod 2^WIDTH: keeps x and p = n*x mod 2^WIDTH and
// clears one bit of p per enabled step so that x converges to n^-1.
module mont_neg_inv
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH,
  parameter int CW    = clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             run,
  input  logic [CW-1:0]    cnt,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] x
);

  localparam int IW = clog2(WIDTH);

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] p_q;
  logic [IW-1:0]    idx;
  logic             step_en;

  assign idx     = cnt[IW-1:0];
  // Bit 0 of p is already 1 for odd n; only bits 1..WIDTH-1 need clearing.
  assign step_en = run && (cnt != '0) && (cnt < CW'(WIDTH));
  assign x       = x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      p_q <= '0;
    end else if (init) begin
      x_q <= WIDTH'(1);
      p_q <= n;
    end else if (step_en && p_q[idx]) begin
      x_q <= x_q | (WIDTH'(1) << idx);
      p_q <= p_q + (n << idx);
    end
  end

endmodule

// File: rtl/mont_param_gen.sv
// Montgomery constant generator: N_INV = -N^-1 mod 2^WIDTH and R2_MOD_N = 2^(2*WIDTH) mod N,
// one shift/add step per cycle. Define MONT_PARAM_RMODN_EN to also export R_MOD_N.
//
// state  | meaning
// IDLE   | waiting for start; results held
// CHECK  | reject even N or N==1, else seed the iterators
// RUN    | 2*WIDTH steps: inverse bits (steps 1..WIDTH-1) and residue doubling (all)
// FINISH | publish results, pulse done
module mont_param_gen
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] N_INV,
  output logic [WIDTH-1:0] R2_MOD_N
`ifdef MONT_PARAM_RMODN_EN
  ,
  output logic [WIDTH-1:0] R_MOD_N
`endif
);

  localparam int CW = clog2(2 * WIDTH);

  mont_state_t      state_q, state_d;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH:0]   r_dbl;
  logic [WIDTH:0]   r_next;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x;
  logic             n_bad;
  logic             run_last;
`ifdef MONT_PARAM_RMODN_EN
  logic [WIDTH-1:0] r_mod_q;
`endif

  assign n_bad    = ~n_q[0] | (n_q == WIDTH'(1));
  assign run_last = (cnt_q == CW'(2 * WIDTH - 1));
  // r < N keeps 2r within WIDTH+1 bits, so one conditional subtract suffices.
  assign r_dbl    = r_q << 1;
  assign r_next   = (r_dbl >= {1'b0, n_q}) ? (r_dbl - {1'b0, n_q}) : r_dbl;

  mont_neg_inv #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_neg_inv (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (state_q == ST_CHECK),
    .run   (state_q == ST_RUN),
    .cnt   (cnt_q),
    .n     (n_q),
    .x     (x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_CHECK;
      ST_CHECK:  state_d = n_bad ? ST_IDLE : ST_RUN;
      ST_RUN:    if (run_last) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      N_INV    <= '0;
      R2_MOD_N <= '0;
`ifdef MONT_PARAM_RMODN_EN
      r_mod_q  <= '0;
      R_MOD_N  <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_q      <= N;
            err      <= 1'b0;
            N_INV    <= '0;
            R2_MOD_N <= '0;
            busy     <= 1'b1;
`ifdef MONT_PARAM_RMODN_EN
            R_MOD_N  <= '0;
`endif
          end
        end
        ST_CHECK: begin
          if (n_bad) begin
            err      <= 1'b1;
            N_INV    <= '0;
            R2_MOD_N <= '0;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            r_q   <= {{WIDTH{1'b0}}, 1'b1};
            cnt_q <= '0;
          end
        end
        ST_RUN: begin
          r_q   <= r_next;
          cnt_q <= cnt_q + CW'(1);
`ifdef MONT_PARAM_RMODN_EN
          // After WIDTH doublings r holds R mod N.
          if (cnt_q == CW'(WIDTH - 1)) r_mod_q <= r_next[WIDTH-1:0];
`endif
        end
        ST_FINISH: begin
          N_INV    <= ~x + WIDTH'(1);
          R2_MOD_N <= r_q[WIDTH-1:0];
          done     <= 1'b1;
          busy     <= 1'b0;
`ifdef MONT_PARAM_RMODN_EN
          R_MOD_N  <= r_mod_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_param_gen.sv
// Scoreboard bench for mont_param_gen: directed vectors plus random moduli checked against
// an arithmetic reference (Newton inverse, 64-bit modulo).
`timescale 1ns/1ps
module tb_mont_param_gen;

  typedef struct {
    logic        err;
    logic [31:0] n_inv;
    logic [31:0] r2;
    logic [31:0] rmod;
    int          lat;
    longint      t0;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] N;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] N_INV;
  logic [31:0] R2_MOD_N;
`ifdef MONT_PARAM_RMODN_EN
  logic [31:0] R_MOD_N;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  mont_param_gen #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .N        (N),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .N_INV    (N_INV),
    .R2_MOD_N (R2_MOD_N)
`ifdef MONT_PARAM_RMODN_EN
    ,
    .R_MOD_N  (R_MOD_N)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic e, input logic [31:0] ni, input logic [31:0] r2,
                              input logic [31:0] rm, input int lat);
    exp_t x;
    x.err = e; x.n_inv = ni; x.r2 = r2; x.rmod = rm; x.lat = lat; x.t0 = 0;
    return x;
  endfunction

  function automatic exp_t model(input logic [31:0] n);
    exp_t        e;
    logic [31:0] x;
    logic [63:0] rm;
    logic [63:0] sq;
    if (!n[0] || n == 32'd1) begin
      e = mk(1'b1, 32'd0, 32'd0, 32'd0, 1);
    end else begin
      x = n;  // correct to 3 bits for odd n; each Newton step doubles that
      for (int i = 0; i < 5; i++) x = x * (32'd2 - n * x);
      rm = 64'h1_0000_0000 % {32'd0, n};
      sq = (rm * rm) % {32'd0, n};
      e  = mk(1'b0, 32'd0 - x, sq[31:0], rm[31:0], 66);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_width", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("err", 32'(err), 32'(mon_e.err));
        chk("n_inv", N_INV, mon_e.n_inv);
        chk("r2_mod_n", R2_MOD_N, mon_e.r2);
`ifdef MONT_PARAM_RMODN_EN
        chk("r_mod_n", R_MOD_N, mon_e.rmod);
`endif
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("latency", 32'(int'(($time - mon_e.t0) / 10) - 1), 32'(mon_e.lat));
      end
    end
    prev_done = done;
  end

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [31:0] n, input exp_t e);
    e.t0 = longint'($time);
    sb.push_back(e);
    start = 1'b1;
    N     = n;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_dir(input logic [31:0] n, input exp_t e);
    issue(n, e);
    wait_empty();
    repeat (3) @(negedge clk);
    chk("hold_n_inv", N_INV, e.n_inv);
    chk("hold_r2", R2_MOD_N, e.r2);
    chk("hold_err", 32'(err), 32'(e.err));
  endtask

  initial begin
    logic [31:0] rn;
    int          sel;
    rst_n = 1'b0;
    start = 1'b0;
    N     = 32'd0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_n_inv", N_INV, 32'd0);
    chk("rst_r2", R2_MOD_N, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_dir(32'd7,          mk(1'b0, 32'h49249249, 32'h2, 32'h4, 66));
    run_dir(32'h8000_0001,  mk(1'b0, 32'h7FFFFFFF, 32'h4, 32'h7FFFFFFF, 66));
    run_dir(32'hFFFF_FFFF,  mk(1'b0, 32'h1, 32'h1, 32'h1, 66));
    run_dir(32'h10,         mk(1'b1, 32'h0, 32'h0, 32'h0, 1));
    run_dir(32'h1,          mk(1'b1, 32'h0, 32'h0, 32'h0, 1));

    // start while busy, with N changed, must be ignored
    issue(32'd7, mk(1'b0, 32'h49249249, 32'h2, 32'h4, 66));
    repeat (9) @(negedge clk);
    start = 1'b1;
    N     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // start in the done cycle is accepted
    issue(32'h8000_0001, model(32'h8000_0001));
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    issue(32'd3, mk(1'b0, 32'h55555555, 32'h1, 32'h1, 66));
    wait_empty();

    // reset in the middle of a run
    issue(32'd7, model(32'd7));
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_n_inv", N_INV, 32'd0);
    chk("midrst_r2", R2_MOD_N, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_dir(32'd3, mk(1'b0, 32'h55555555, 32'h1, 32'h1, 66));

    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 7));
      rn  = $urandom;
      if (sel == 0)      rn = rn & ~32'd1;
      else if (sel == 1) rn = 32'd1;
      else               rn = rn | 32'd1;
      run_dir(rn, model(rn));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
